// File: rtl/uart_stream_arbiter.sv
// uart_stream_arbiter
// Shares one UART transmitter between the audio stream and the YIN taumin
// result. Each source has a 1-deep holding register. A taumin result is sent
// as a two-word frame {MARKER, payload}. Audio words that collide with MARKER
// are escaped to MARKER+1 so the host can always find frame starts.
module uart_stream_arbiter #(
    parameter logic [15:0] MARKER      = 16'h8000,
    parameter int          ACK_TIMEOUT = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] audio_in,
    input  logic        audio_valid_in,
    input  logic [10:0] taumin_in,
    input  logic        taumin_valid_in,
    input  logic        enable_in,
    input  logic        uart_busy_in,
    output logic [15:0] uart_data_out,
    output logic        uart_trigger_out,
    output logic        busy_out,
    output logic [7:0]  audio_drops_out,
    output logic [7:0]  tau_drops_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_r;
    state_t      next_state_s;

    logic [15:0] audio_hold_r;
    logic        audio_full_r;
    logic [10:0] tau_hold_r;
    logic        tau_full_r;
    logic [7:0]  audio_drops_r;
    logic [7:0]  tau_drops_r;

    logic [15:0] data_r;
    logic [15:0] payload_r;
    logic        tau_frame_r;
    logic        last_tau_r;
    logic        trigger_r;
    logic [7:0]  wait_cnt_r;

    logic        grant_audio_s;
    logic        grant_tau_s;
    logic        load_s;
    logic [15:0] load_value_s;
    logic        frame_set_s;
    logic        frame_clr_s;

    // Escape audio samples that would be mistaken for a frame start.
    function automatic logic [15:0] escape_audio(input logic [15:0] value);
        logic [15:0] result;
        if (value == MARKER) begin
            result = MARKER + 16'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Next-state, grant and word-load decisions.
    always_comb begin
        next_state_s  = state_r;
        grant_audio_s = 1'b0;
        grant_tau_s   = 1'b0;
        load_s        = 1'b0;
        load_value_s  = data_r;
        frame_set_s   = 1'b0;
        frame_clr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable_in && !uart_busy_in && (audio_full_r || tau_full_r)) begin
                    if (audio_full_r && tau_full_r) begin
                        // Round-robin: favour the channel not served last.
                        if (last_tau_r) begin
                            grant_audio_s = 1'b1;
                        end else begin
                            grant_tau_s = 1'b1;
                        end
                    end else if (audio_full_r) begin
                        grant_audio_s = 1'b1;
                    end else begin
                        grant_tau_s = 1'b1;
                    end
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
                if (grant_audio_s) begin
                    load_s       = 1'b1;
                    load_value_s = escape_audio(audio_hold_r);
                end else if (grant_tau_s) begin
                    load_s       = 1'b1;
                    load_value_s = MARKER;
                    frame_set_s  = 1'b1;
                end else begin
                    load_s       = 1'b0;
                end
            end
            ISSUE: begin
                next_state_s = WAIT_HI;
            end
            WAIT_HI: begin
                if (uart_busy_in) begin
                    next_state_s = WAIT_LO;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    // Transmitter never acknowledged; treat the word as sent.
                    next_state_s = WAIT_LO;
                end else begin
                    next_state_s = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (!uart_busy_in) begin
                    if (tau_frame_r) begin
                        // Second frame word goes out regardless of enable/arbitration.
                        load_s       = 1'b1;
                        load_value_s = payload_r;
                        frame_clr_s  = 1'b1;
                        next_state_s = ISSUE;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = WAIT_LO;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Audio holding register and its saturating overwrite counter.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            audio_hold_r  <= 16'd0;
            audio_full_r  <= 1'b0;
            audio_drops_r <= 8'd0;
        end else if (audio_valid_in) begin
            audio_hold_r <= audio_in;
            audio_full_r <= 1'b1;
            if (audio_full_r && !grant_audio_s && (audio_drops_r != 8'hFF)) begin
                audio_drops_r <= audio_drops_r + 8'd1;
            end else begin
                audio_drops_r <= audio_drops_r;
            end
        end else if (grant_audio_s) begin
            audio_full_r <= 1'b0;
        end else begin
            audio_full_r <= audio_full_r;
        end
    end

    // Taumin holding register and its saturating overwrite counter.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tau_hold_r  <= 11'd0;
            tau_full_r  <= 1'b0;
            tau_drops_r <= 8'd0;
        end else if (taumin_valid_in) begin
            tau_hold_r <= taumin_in;
            tau_full_r <= 1'b1;
            if (tau_full_r && !grant_tau_s && (tau_drops_r != 8'hFF)) begin
                tau_drops_r <= tau_drops_r + 8'd1;
            end else begin
                tau_drops_r <= tau_drops_r;
            end
        end else if (grant_tau_s) begin
            tau_full_r <= 1'b0;
        end else begin
            tau_full_r <= tau_full_r;
        end
    end

    // Output word, frame payload, round-robin memory, trigger and ack timer.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            data_r      <= 16'd0;
            payload_r   <= 16'd0;
            tau_frame_r <= 1'b0;
            last_tau_r  <= 1'b1;
            trigger_r   <= 1'b0;
            wait_cnt_r  <= 8'd0;
        end else begin
            if (load_s) begin
                data_r <= load_value_s;
            end else begin
                data_r <= data_r;
            end
            if (grant_tau_s) begin
                payload_r  <= {5'b00000, tau_hold_r};
                last_tau_r <= 1'b1;
            end else if (grant_audio_s) begin
                last_tau_r <= 1'b0;
            end else begin
                last_tau_r <= last_tau_r;
            end
            if (frame_set_s) begin
                tau_frame_r <= 1'b1;
            end else if (frame_clr_s) begin
                tau_frame_r <= 1'b0;
            end else begin
                tau_frame_r <= tau_frame_r;
            end
            trigger_r <= (state_r == ISSUE);
            if (state_r == WAIT_HI) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
        end
    end

    assign uart_data_out    = data_r;
    assign uart_trigger_out = trigger_r;
    assign audio_drops_out  = audio_drops_r;
    assign tau_drops_out    = tau_drops_r;
    assign busy_out         = audio_full_r || tau_full_r || (state_r != IDLE);

endmodule

// File: tb/tb_uart_stream_arbiter.sv
// Testbench for uart_stream_arbiter: UART transmitter model, expected-word
// queue built from the scenario, per-cycle compare of triggers and drop counts.
module tb_uart_stream_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] audio_in;
    logic        audio_valid_in;
    logic [10:0] taumin_in;
    logic        taumin_valid_in;
    logic        enable_in;
    logic        uart_busy_in;
    logic [15:0] uart_data_out;
    logic        uart_trigger_out;
    logic        busy_out;
    logic [7:0]  audio_drops_out;
    logic [7:0]  tau_drops_out;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          exp_adrops = 0;
    int          exp_tdrops = 0;
    int          cyc = 0;
    int          ub_cnt = 0;
    int          ub_len = 20;
    bit          never_busy = 1'b0;
    logic        prev_trig = 1'b0;

    uart_stream_arbiter dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .audio_in        (audio_in),
        .audio_valid_in  (audio_valid_in),
        .taumin_in       (taumin_in),
        .taumin_valid_in (taumin_valid_in),
        .enable_in       (enable_in),
        .uart_busy_in    (uart_busy_in),
        .uart_data_out   (uart_data_out),
        .uart_trigger_out(uart_trigger_out),
        .busy_out        (busy_out),
        .audio_drops_out (audio_drops_out),
        .tau_drops_out   (tau_drops_out)
    );

    always #5 clk_in = ~clk_in;

    // UART transmitter model: busy for ub_len cycles after seeing a trigger.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (uart_trigger_out && !never_busy) begin
            ub_cnt <= ub_len;
        end else if (ub_cnt > 0) begin
            ub_cnt <= ub_cnt - 1;
        end
    end
    assign uart_busy_in = (ub_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Per-cycle compare: drop counters and every transmitted word.
    always @(negedge clk_in) begin
        if (rst_in) begin
            check("audio_drops", {24'd0, audio_drops_out}, exp_adrops);
            check("tau_drops", {24'd0, tau_drops_out}, exp_tdrops);
            if (uart_trigger_out) begin
                check("trigger_single_cycle", {31'd0, prev_trig}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_trigger actual=%0h required=none", uart_data_out);
                end else begin
                    check("tx_word", {16'd0, uart_data_out}, {16'd0, exp_q.pop_front()});
                end
            end
        end
        prev_trig <= uart_trigger_out;
    end

    function automatic logic [15:0] audio_word(input logic [15:0] v);
        return (v == 16'h8000) ? 16'h8001 : v;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        rst_in          = 1'b0;
        audio_valid_in  = 1'b0;
        taumin_valid_in = 1'b0;
        audio_in        = 16'd0;
        taumin_in       = 11'd0;
        enable_in       = 1'b0;
        exp_q.delete();
        exp_adrops      = 0;
        exp_tdrops      = 0;
        tick(2);
        rst_in = 1'b1;
    endtask

    task automatic strobe_audio(input logic [15:0] v, input bit drop);
        audio_in       = v;
        audio_valid_in = 1'b1;
        tick(1);
        audio_valid_in = 1'b0;
        if (drop) exp_adrops = sat_inc(exp_adrops);
    endtask

    task automatic strobe_tau(input logic [10:0] v, input bit drop);
        taumin_in       = v;
        taumin_valid_in = 1'b1;
        tick(1);
        taumin_valid_in = 1'b0;
        if (drop) exp_tdrops = sat_inc(exp_tdrops);
    endtask

    task automatic wait_trig(input int budget, output int at);
        bit found = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk_in);
            if (uart_trigger_out) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL trigger_timeout actual=none required=trigger within %0d", budget);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk_in);
            if (exp_q.size() == 0 && !busy_out && !uart_busy_in) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_words_left busy=%0b required=idle", exp_q.size(), busy_out);
        end
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        rst_in          = 1'b0;
        audio_in        = 16'd0;
        audio_valid_in  = 1'b0;
        taumin_in       = 11'd0;
        taumin_valid_in = 1'b0;
        enable_in       = 1'b0;

        // Test 1: single audio word, reset state and latency.
        do_reset();
        check("rst_data", {16'd0, uart_data_out}, 32'd0);
        check("rst_trigger", {31'd0, uart_trigger_out}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_adrops", {24'd0, audio_drops_out}, 32'd0);
        check("rst_tdrops", {24'd0, tau_drops_out}, 32'd0);
        enable_in = 1'b1;
        ub_len    = 20;
        exp_q.push_back(16'h1234);
        strobe_audio(16'h1234, 1'b0);
        check("t1_busy_after_strobe", {31'd0, busy_out}, 32'd1);
        tick(1);
        check("t1_data_k1", {16'd0, uart_data_out}, 32'h1234);
        check("t1_trig_k1", {31'd0, uart_trigger_out}, 32'd0);
        tick(1);
        check("t1_trig_k2", {31'd0, uart_trigger_out}, 32'd1);
        wait_drain(200);
        check("t1_busy_end", {31'd0, busy_out}, 32'd0);

        // Test 2: taumin frame stays whole though enable drops and audio waits.
        do_reset();
        enable_in = 1'b1;
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h012C);
        strobe_tau(11'd300, 1'b0);
        strobe_audio(16'h0555, 1'b0);
        wait_trig(50, t1);
        enable_in = 1'b0;
        tick(60);
        check("t2_frame_sent", exp_q.size(), 32'd0);
        check("t2_audio_pending_busy", {31'd0, busy_out}, 32'd1);
        exp_q.push_back(16'h0555);
        enable_in = 1'b1;
        wait_drain(200);

        // Test 3: simultaneous strobes; last-grant is TAU after reset so audio leads.
        do_reset();
        enable_in = 1'b1;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h0005);
        audio_in        = 16'h1111;
        taumin_in       = 11'd5;
        audio_valid_in  = 1'b1;
        taumin_valid_in = 1'b1;
        tick(1);
        audio_valid_in  = 1'b0;
        taumin_valid_in = 1'b0;
        wait_drain(300);

        // Test 4: audio overwrites saturate at 255; last sample wins; tau drop.
        do_reset();
        enable_in = 1'b1;
        ub_len    = 100;
        exp_q.push_back(16'h4000);
        strobe_audio(16'h4000, 1'b0);
        wait_trig(50, t1);
        enable_in = 1'b0;
        for (int i = 0; i < 300; i++) begin
            strobe_audio(16'h1000 + 16'(i), i != 0);
            tick(4);
        end
        check("t4_adrops_sat", {24'd0, audio_drops_out}, 32'd255);
        strobe_tau(11'd7, 1'b0);
        strobe_tau(11'd9, 1'b1);
        check("t4_tdrops", {24'd0, tau_drops_out}, 32'd1);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h0009);
        exp_q.push_back(16'h112B);
        enable_in = 1'b1;
        wait_drain(800);

        // Test 5: MARKER escape; strobe on the consume cycle is not a drop.
        do_reset();
        enable_in = 1'b1;
        ub_len    = 20;
        exp_q.push_back(audio_word(16'h8000));
        exp_q.push_back(audio_word(16'h7FFF));
        strobe_audio(16'h8000, 1'b0);
        strobe_audio(16'h7FFF, 1'b0);
        wait_drain(200);
        check("t5_escape_literal", {16'd0, audio_word(16'h8000)}, 32'h8001);

        // Test 6a: UART never acknowledges; WAIT_HI times out.
        do_reset();
        never_busy = 1'b1;
        enable_in  = 1'b1;
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h3333);
        strobe_audio(16'h2222, 1'b0);
        wait_trig(50, t1);
        strobe_audio(16'h3333, 1'b0);
        wait_trig(50, t2);
        check("t6_timeout_gap", t2 - t1, 32'd11);
        wait_drain(100);

        // Test 6b: reset while waiting for busy to fall aborts everything.
        never_busy = 1'b0;
        ub_len     = 20;
        do_reset();
        enable_in = 1'b1;
        exp_q.push_back(16'h4444);
        strobe_audio(16'h4444, 1'b0);
        wait_trig(50, t1);
        tick(5);
        strobe_audio(16'h5555, 1'b0);
        rst_in = 1'b0;
        exp_q.delete();
        exp_adrops = 0;
        exp_tdrops = 0;
        tick(1);
        check("t6_rst_data", {16'd0, uart_data_out}, 32'd0);
        check("t6_rst_trigger", {31'd0, uart_trigger_out}, 32'd0);
        check("t6_rst_busy", {31'd0, busy_out}, 32'd0);
        check("t6_rst_adrops", {24'd0, audio_drops_out}, 32'd0);
        tick(1);
        rst_in = 1'b1;
        tick(60);
        check("t6_post_rst_busy", {31'd0, busy_out}, 32'd0);
        check("t6_post_rst_data", {16'd0, uart_data_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
